// File: rtl/zephyr_core.sv
// zephyr_core: multicycle fetch/decode/execute controller for the zephyr CPU.
// Contains the register file, the ALU and the instruction register. Talks to a
// unified instruction/data memory over a REQ/ACK handshake, so the memory may
// stretch any transaction with wait states.
//
// Ports:
//   CLK        in   1       rising-edge clock
//   RESET      in   1       asynchronous, active-high reset
//   MEM_REQ    out  1       memory request, held until MEM_ACK is sampled high
//   MEM_WE     out  1       1 = write, 0 = read (valid while MEM_REQ)
//   MEM_ADDR   out  ADDR_W  memory address (stable while MEM_REQ)
//   MEM_WDATA  out  DATA_W  store data (valid while MEM_REQ && MEM_WE)
//   MEM_RDATA  in   DATA_W  read data, sampled on the edge where MEM_REQ && MEM_ACK
//   MEM_ACK    in   1       transaction completion, ignored while MEM_REQ is low
//   RETIRE     out  1       one-cycle pulse after an instruction completes
//   DBG_PC     out  ADDR_W  current program counter
//   FLAG_Z     out  1       last ALU result was zero
//   FLAG_C     out  1       last ALU carry (ADD) / no-borrow (SUB), 0 after AND/XOR
//   HALTED     out  1       core is parked in HALT
//
// Instruction word: [DATA_W-1:DATA_W-2] opcode, next SEL_W bits RD, low ADDR_W
// bits memory address (LOAD/STR); ALU ops use [SEL_W+1:2] as RS and [1:0] as FN.
//
// Optional feature macro: ZEPHYR_HALT_EN. When defined, a NOP whose low
// DATA_W-2 bits are all ones halts the core until RESET. When undefined that
// encoding is an ordinary NOP and HALTED is tied low.
module zephyr_core #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic              RETIRE,
  output logic [ADDR_W-1:0] DBG_PC,
  output logic              FLAG_Z,
  output logic              FLAG_C,
  output logic              HALTED
);

  localparam int SEL_W = $clog2(NREG);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_STR  = 2'b10;
  localparam logic [1:0] OP_ALU  = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [1:0]          op_q, op_d;
  logic [SEL_W-1:0]    rd_q, rd_d;
  logic [SEL_W-1:0]    rs_q, rs_d;
  logic [1:0]          fn_q, fn_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   ldata_q, ldata_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic                flag_z_q, flag_z_d;
  logic                flag_c_q, flag_c_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                retire_q, retire_d;

  logic [ADDR_W-1:0]   pc_inc;
  logic [DATA_W:0]     alu_res;
  logic                halt_now;

  // Result in the low DATA_W bits, carry / no-borrow in the top bit.
  // SUB is a + ~b + 1, so the carry-out is 1 exactly when no borrow occurs.
  function automatic logic [DATA_W:0] alu_f(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [1:0]        fn);
    logic [DATA_W:0] r;
    case (fn)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  assign pc_inc  = pc_q + ADDR_W'(1);
  assign alu_res = alu_f(regs_q[rd_q], regs_q[rs_q], fn_q);

`ifdef ZEPHYR_HALT_EN
  logic halted_q, halted_d;

  // IR still holds the instruction during EXECUTE, so decode HALT straight from it.
  assign halt_now = (op_q == OP_NOP) && (&ir_q[DATA_W-3:0]);
  assign halted_d = halted_q || ((state_q == S_EXECUTE) && halt_now);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end

  assign HALTED = halted_q;
`else
  assign halt_now = 1'b0;
  assign HALTED   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    fn_d        = fn_q;
    addr_d      = addr_q;
    ldata_d     = ldata_q;
    regs_d      = regs_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    retire_d    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!mem_req_q) begin
          // Only reached straight out of reset; every other entry into
          // FETCH already raises the request for the next PC.
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end else if (MEM_ACK) begin
          ir_d      = MEM_RDATA;
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        op_d    = ir_q[DATA_W-1 -: 2];
        rd_d    = ir_q[DATA_W-3 -: SEL_W];
        rs_d    = ir_q[SEL_W+1:2];
        fn_d    = ir_q[1:0];
        addr_d  = ir_q[ADDR_W-1:0];
        state_d = S_EXECUTE;
      end

      S_EXECUTE: begin
        case (op_q)
          OP_LOAD: begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = addr_q;
            state_d    = S_MEM;
          end
          OP_STR: begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = regs_q[rd_q];
            state_d     = S_MEM;
          end
          default: begin
            retire_d = 1'b1;
            if (halt_now) begin
              state_d = S_HALT;
            end else begin
              if (op_q == OP_ALU) begin
                regs_d[rd_q] = alu_res[DATA_W-1:0];
                flag_z_d     = (alu_res[DATA_W-1:0] == '0);
                flag_c_d     = alu_res[DATA_W];
              end
              pc_d       = pc_inc;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = pc_inc;
              state_d    = S_FETCH;
            end
          end
        endcase
      end

      S_MEM: begin
        if (MEM_ACK) begin
          if (mem_we_q) begin
            // Store done: go straight into the next fetch, keeping REQ high.
            pc_d       = pc_inc;
            retire_d   = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_inc;
            state_d    = S_FETCH;
          end else begin
            ldata_d   = MEM_RDATA;
            mem_req_d = 1'b0;
            state_d   = S_WB;
          end
        end
      end

      S_WB: begin
        regs_d[rd_q] = ldata_q;
        pc_d         = pc_inc;
        retire_d     = 1'b1;
        mem_req_d    = 1'b1;
        mem_we_d     = 1'b0;
        mem_addr_d   = pc_inc;
        state_d      = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      fn_q        <= '0;
      addr_q      <= '0;
      ldata_q     <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      retire_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      fn_q        <= fn_d;
      addr_q      <= addr_d;
      ldata_q     <= ldata_d;
      regs_q      <= regs_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      retire_q    <= retire_d;
    end
  end

  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign RETIRE    = retire_q;
  assign DBG_PC    = pc_q;
  assign FLAG_Z    = flag_z_q;
  assign FLAG_C    = flag_c_q;

endmodule
